// File: rtl/regfile_2r1w_clr_if.sv
// Bus bundle for the dual-read, single-write register file with clear engine.
// The master drives write/read requests; the slave returns read data and busy.
interface regfile_2r1w_clr_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 3
);
  logic             write;
  logic [AW-1:0]    writenum;
  logic [WIDTH-1:0] data_in;
  logic [AW-1:0]    readnum_a;
  logic [AW-1:0]    readnum_b;
  logic             clear;
  logic [WIDTH-1:0] data_out_a;
  logic [WIDTH-1:0] data_out_b;
  logic             busy;

  modport master (
    output write, writenum, data_in, readnum_a, readnum_b, clear,
    input  data_out_a, data_out_b, busy
  );

  modport slave (
    input  write, writenum, data_in, readnum_a, readnum_b, clear,
    output data_out_a, data_out_b, busy
  );
endinterface

// File: rtl/regfile_2r1w_clr.sv
// NREGS x WIDTH register file: one write port, two combinational read ports,
// optional write-to-read bypass and a one-entry-per-cycle clear sweep.
module regfile_2r1w_clr #(
  parameter int WIDTH  = 16,
  parameter int NREGS  = 8,
  parameter int AW     = 3,
  parameter int BYPASS = 1
) (
  input logic               clk,
  input logic               reset,
  regfile_2r1w_clr_if.slave bus
);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t           state_q, state_d;
  logic [AW-1:0]    ptr_q, ptr_d;
  logic [WIDTH-1:0] mem_q [NREGS];
  logic [WIDTH-1:0] mem_d [NREGS];

  logic busy;
  logic wr_in_range;
  logic rd_a_in_range;
  logic rd_b_in_range;
  logic fwd_ok;

  assign busy          = reset || (state_q == CLEAR);
  assign wr_in_range   = 32'(bus.writenum) < NREGS;
  assign rd_a_in_range = 32'(bus.readnum_a) < NREGS;
  assign rd_b_in_range = 32'(bus.readnum_b) < NREGS;
  assign fwd_ok        = (BYPASS != 0) && bus.write && !bus.clear;

  // A clear request in IDLE takes priority over a write in the same cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_d   = mem_q;
    if (state_q == CLEAR) begin
      mem_d[ptr_q] = '0;
      if (ptr_q == LAST_IDX) begin
        state_d = IDLE;
        ptr_d   = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end else if (bus.clear) begin
      state_d = CLEAR;
      ptr_d   = '0;
    end else if (bus.write && wr_in_range) begin
      mem_d[bus.writenum] = bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    bus.data_out_a = '0;
    if (!busy && rd_a_in_range) begin
      if (fwd_ok && (bus.readnum_a == bus.writenum)) begin
        bus.data_out_a = bus.data_in;
      end else begin
        bus.data_out_a = mem_q[bus.readnum_a];
      end
    end
  end

  always_comb begin
    bus.data_out_b = '0;
    if (!busy && rd_b_in_range) begin
      if (fwd_ok && (bus.readnum_b == bus.writenum)) begin
        bus.data_out_b = bus.data_in;
      end else begin
        bus.data_out_b = mem_q[bus.readnum_b];
      end
    end
  end

  assign bus.busy = busy;

endmodule

// File: doc/regfile_2r1w_clr.md
Name: regfile_2r1w_clr

Overview:
Parametrised successor to the 8x16 single-read register file. It provides one write port and two independent combinational read ports, so the datapath can fetch both ALU operands in one cycle. A configurable write-to-read bypass is included. A sequential clear engine zeroes every register, one entry per cycle, after reset or on request, and reports progress on a busy flag.

Parameters:
WIDTH, 16, data width of each register in bits
NREGS, 8, number of registers; legal range 2..256
AW, 3, address width; must satisfy 2**AW >= NREGS
BYPASS, 1, 1 = same-cycle write data forwarded to a matching read port; 0 = reads return stored contents only

Ports:
clk  input  1  rising-edge clock, sole clock domain
reset  input  1  synchronous, active-high reset
write  input  1  write enable, sampled on rising clk
writenum  input  AW  write register index
data_in  input  WIDTH  write data
readnum_a  input  AW  read port A index
readnum_b  input  AW  read port B index
clear  input  1  request a full clear sweep (level, sampled in IDLE)
data_out_a  output  WIDTH  read port A data (combinational)
data_out_b  output  WIDTH  read port B data (combinational)
busy  output  1  high while reset is asserted or a clear sweep is in progress

Behaviour:
- Storage: NREGS x WIDTH flops. Register contents are undefined until the first sweep completes.
- FSM states: CLEAR, IDLE. Registered sweep pointer ptr, width AW.
- Reset:
  - While reset is high at an edge: state <= CLEAR, ptr <= 0, no storage write.
  - busy = 1; data_out_a = data_out_b = 0.
  - Reset asserted mid-sweep restarts the sweep from ptr 0.
- CLEAR state, each edge with reset low:
  - reg[ptr] <= 0, ptr <= ptr + 1.
  - At ptr == NREGS-1: reg[NREGS-1] <= 0, state <= IDLE, ptr <= 0.
  - busy is high for exactly NREGS cycles after reset deasserts, then falls.
- IDLE state, clear = 1 at an edge: state <= CLEAR, ptr <= 0. No write is performed that cycle, even if write = 1.
- clear while in CLEAR is ignored; it does not restart or extend the sweep.
- Write port:
  - In IDLE with write = 1, clear = 0 and writenum < NREGS: reg[writenum] <= data_in at the edge.
  - Writes while busy = 1 are silently dropped.
  - writenum >= NREGS is ignored.
- Read ports, combinational, zero latency:
  - busy = 1: output 0.
  - Else readnum >= NREGS: output 0.
  - Else BYPASS = 1, write = 1, clear = 0 and readnum == writenum: output data_in.
  - Else output reg[readnum].
  - Both ports may read the same index; each port is evaluated independently.
- Read data for a written register reflects the new value from the cycle after the write edge (or the same cycle via bypass).
- No output is registered. busy is decoded from state and reset only, with no glitches from data inputs.

Test Plan:
- Reset release: hold reset 3 cycles, then release. Required: busy = 1 for exactly 8 more cycles; afterwards readnum_a = 0..7 all read 0x0000.
- Dual read: write R3 = 0x1234, then R5 = 0xBEEF. Next cycle readnum_a = 3, readnum_b = 5 gives 0x1234 / 0xBEEF; readnum_a = readnum_b = 5 gives 0xBEEF on both.
- Bypass: BYPASS = 1, write = 1, writenum = 2, data_in = 0xA5A5, readnum_a = 2 gives 0xA5A5 in the same cycle. With BYPASS = 0, the same stimulus gives the old R2 value, then 0xA5A5 the next cycle.
- Clear request: fill R0..R7 with 0x0101*k, then pulse clear with write = 1 to R1. Required: busy for 8 cycles, the R1 write is dropped, all registers then read 0. A write during busy has no effect afterwards.
- Reset mid-sweep: assert reset at sweep cycle 4 for 1 cycle. Required: busy stays high and a full 8-cycle sweep restarts from R0.
- Non-power-of-two: NREGS = 6, AW = 3. Required: sweep takes 6 cycles; write to index 7 is ignored; readnum 6/7 returns 0.
